// File: rtl/gray_cnt_pkg.sv
// Shared definitions for the Gray-code counter family: count directions and
// the binary-to-Gray encoder used by every Gray block.
package gray_cnt_pkg;

  localparam int GRAY_MAX_WIDTH = 16;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Widest supported encoder; narrower callers zero-extend and truncate.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_param_gray2bin.sv
// Purely combinational Gray-to-binary decoder (prefix XOR from the MSB down).
// Kept standalone so it can also decode synchronised CDC pointers.
module gray2bin
  import gray_cnt_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the parity of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bin[gi] = ^gray[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with load, sticky overflow/underflow and
// wrap pulse. Define GRAY_CNT_SAT_EN to saturate at the ends instead of wrapping.
module gray_counter_param
  import gray_cnt_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int INIT  = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadGray,
  input  logic             ClrFlag,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(INIT);

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] gray_reg, gray_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             wrap_reg, wrap_next;
  logic             ovf_set, unf_set;
  logic [WIDTH-1:0] load_bin;

  gray2bin #(.WIDTH(WIDTH)) u_load_dec (
    .gray (LoadGray),
    .bin  (load_bin)
  );

  always_comb begin
    cnt_next  = cnt_reg;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    wrap_next = 1'b0;
    if (Load) begin
      cnt_next = load_bin;
    end else if (En) begin
      if (Dir == DIR_UP) begin
        if (cnt_reg == CNT_MAX) begin
          ovf_set = 1'b1;
`ifdef GRAY_CNT_SAT_EN
          cnt_next = CNT_MAX;
`else
          cnt_next  = '0;
          wrap_next = 1'b1;
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end else begin
        if (cnt_reg == '0) begin
          unf_set = 1'b1;
`ifdef GRAY_CNT_SAT_EN
          cnt_next = '0;
`else
          cnt_next  = CNT_MAX;
          wrap_next = 1'b1;
`endif
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
    end
    // A wrap in the same cycle as a clear leaves its flag set.
    ovf_next  = ovf_set | (ovf_reg & ~ClrFlag);
    unf_next  = unf_set | (unf_reg & ~ClrFlag);
    gray_next = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(cnt_next)));
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_reg  <= CNT_INIT;
      gray_reg <= WIDTH'(bin2gray(GRAY_MAX_WIDTH'(CNT_INIT)));
      ovf_reg  <= 1'b0;
      unf_reg  <= 1'b0;
      wrap_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      gray_reg <= gray_next;
      ovf_reg  <= ovf_next;
      unf_reg  <= unf_next;
      wrap_reg <= wrap_next;
    end
  end

  assign Output    = gray_reg;
  assign Binary    = cnt_reg;
  assign Overflow  = ovf_reg;
  assign Underflow = unf_reg;
  assign Wrap      = wrap_reg;

endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
Parametrised up/down Gray-code counter, the next generation of the team's fixed 3-bit Gray counter. It adds configurable width, a count direction, a synchronous load, and sticky overflow/underflow flags that can be cleared. It also drives a one-cycle wrap pulse. It sits as a leaf counter feeding pointer/sequencer logic that needs single-bit-change outputs.

Parameters:
WIDTH, 3, counter width in bits (legal range 2..16).
INIT, 0, binary reset value of the internal count (0..2^WIDTH-1).

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset (0 = reset, sampled on Clk rising edge)
En  input  1  count enable
Dir  input  1  0 = count up, 1 = count down
Load  input  1  synchronous load strobe
LoadGray  input  WIDTH  value to load, Gray-encoded
ClrFlag  input  1  clears Overflow and Underflow
Output  output  WIDTH  current count, Gray-encoded (registered)
Binary  output  WIDTH  current count, binary (registered)
Overflow  output  1  sticky: up-count wrapped from max to 0
Underflow  output  1  sticky: down-count wrapped from 0 to max
Wrap  output  1  one-cycle pulse on any wrap

Behaviour:
- Internal state is a binary count cnt[WIDTH-1:0]. Output = cnt ^ (cnt >> 1) and Binary = cnt.
- Output and Binary always reflect the same cnt, registered. There is no extra pipeline stage: the value updated at edge N is visible right after edge N.
- Reset == 0 at an edge: cnt = INIT, Overflow = 0, Underflow = 0, Wrap = 0. Reset wins over every other input. Reset mid-count discards the count.
- Priority when Reset == 1: Load > En. ClrFlag is evaluated independently of Load/En.
- Load == 1:
  - cnt = gray2bin(LoadGray).
  - No count that cycle, even if En == 1.
  - Flags are unchanged apart from ClrFlag. Wrap = 0.
- En == 1, Load == 0, Dir == 0:
  - cnt = cnt + 1, mod 2^WIDTH.
  - If cnt was 2^WIDTH-1: cnt becomes 0, Overflow = 1, Wrap = 1.
- En == 1, Load == 0, Dir == 1:
  - cnt = cnt - 1, mod 2^WIDTH.
  - If cnt was 0: cnt becomes 2^WIDTH-1, Underflow = 1, Wrap = 1.
- En == 0, Load == 0: cnt holds, Wrap = 0.
- Wrap is high for exactly the cycle after the wrapping edge. Otherwise it is 0.
- ClrFlag == 1: Overflow and Underflow go to 0, except that a wrap occurring in the same cycle sets its flag. Set wins over clear.
- Flags are otherwise sticky until Reset or ClrFlag.
- Each count step changes exactly one bit of Output, including across the wrap.
- A direction change takes effect on the same edge. There are no hidden states.

Optional Feature:
GRAY_CNT_SAT_EN
- Defined: the counter saturates instead of wrapping.
  - Up at max: cnt holds 2^WIDTH-1 and Overflow = 1.
  - Down at 0: cnt holds 0 and Underflow = 1.
  - Wrap is never asserted (tied 0).
- Not defined: wrap-around behaviour as above.

Decomposition:
- Package gray_cnt_pkg holds:
  - DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
  - A bin2gray function, cnt ^ (cnt >> 1), shared by other Gray blocks.
- Sub-module gray2bin (parameter WIDTH) is the purely combinational prefix-XOR decoder for LoadGray. It is instantiated once. It is reusable for CDC pointer decode.

Test Plan:
- WIDTH=3, Reset low 1 cycle, then En=1, Dir=0 for 9 cycles:
  - Output = 000,001,011,010,110,111,101,100,000.
  - Overflow rises with the final 000 and Wrap pulses that cycle only.
- From reset (cnt=0), En=1, Dir=1 one cycle:
  - Output=100, Binary=111, Underflow=1, Wrap=1.
  - Next cycle with En=0: Wrap=0 and Underflow stays 1.
- Load=1, LoadGray=101, En=1 same cycle:
  - Binary=110, Output=101, no count.
  - Next cycle up-count gives Output=100, Binary=111.
- Overflow=1, then ClrFlag=1 alone: Overflow=0.
- Then count to max and on the wrapping edge assert ClrFlag=1: Overflow=1 (set wins).
- Mid-count (Binary=101) drive Reset=0 with En=1, Load=1: Binary=INIT=000, Output=000, all flags 0.
- GRAY_CNT_SAT_EN defined, WIDTH=3, En=1, Dir=0 for 10 cycles:
  - Output sticks at 100 (Binary 111).
  - Overflow=1, Wrap never 1.
